dual_fetch_queue: RTL
=====================

// Module: dual_fetch_queue
// PURPOSE
//  Front-end instruction queue feeding the dual-issue relayer. Fetches 16-bit instructions
//  from instruction memory two words per request, buffers them in order, and presents
//  the two oldest as an issue pair. The relayer returns how many it took (0/1/2) each cycle.
//  Split issue on a hazard leaves the second instruction at the head for the next pair.
//  Branch redirects flush the queue and restart fetch.
// PARAMETERS
//  DEPTH     8        queue entries; power of 2, >= 4
//  RESET_PC  16'h0000 first fetch word address after reset
// PORTS
//  clk            in   1   rising-edge clock
//  rst            in   1   synchronous, active-high reset
//  imem_req       out  1   fetch request this cycle
//  imem_addr      out  16  word address of first word; second word is imem_addr+1 (mod 2^16)
//  imem_rdata1    in   16  word at imem_addr, valid exactly 1 cycle after imem_req
//  imem_rdata2    in   16  word at imem_addr+1, same timing
//  redirect_valid in   1   flush and restart fetch at redirect_pc
//  redirect_pc    in   16  new fetch word address
//  instr1_out     out  16  oldest queued instruction (NOP 16'h0000 when invalid)
//  instr2_out     out  16  second-oldest instruction (NOP 16'h0000 when invalid)
//  instr1_valid   out  1   instr1_out holds a real instruction
//  instr2_valid   out  1   instr2_out holds a real instruction
//  consume        in   2   instructions taken by relayer this cycle: 0, 1 or 2
// BEHAVIOUR
//  - Reset: pc=RESET_PC, queue empty (count=0, rd/wr ptr=0), inflight=0, imem_req=0,
//    instr*_valid=0, instr*_out=NOP. Reset mid-fetch discards the returning response.
//  - Outputs instr1/2_out/valid are combinational from head and head+1 of the queue.
//  - Legal consume: <= number of valid outputs. Illegal values (3, or more than valid)
//    are clamped to the valid count; the bench flags them as protocol errors.
//  - Fetch: imem_req=1 when !redirect_valid and count - consume_eff + 2*inflight + 2 <= DEPTH.
//    On request: imem_addr=pc, pc<=pc+2 (wraps mod 2^16), inflight<=1 for next cycle.
//    A new request may be issued every cycle (back-to-back) if space allows.
//  - Response: in the cycle after a request (inflight=1), rdata1 is written at wr_ptr,
//    rdata2 at wr_ptr+1; wr_ptr+=2, count+=2. Pointers wrap mod DEPTH.
//  - Per cycle: count_next = count - consume_eff + (inflight ? 2 : 0); never exceeds DEPTH.
//  - Simultaneous consume and write in the same cycle are both applied.
//  - Empty queue with a response arriving: data is visible on outputs the following cycle
//    (no same-cycle bypass); fetch-to-issue latency is 2 cycles.
//  - Redirect (highest priority, over consume and response): count<=0, rd_ptr=wr_ptr=0,
//    inflight<=0 (in-flight response is dropped), pc<=redirect_pc, imem_req=0 that cycle;
//    fetch resumes at redirect_pc next cycle. Outputs are invalid the cycle after redirect.
//  - No state machine beyond the inflight flag; FULL when count==DEPTH (no request issued),
//    EMPTY when count==0 (both valids low), count==1 -> only instr1_valid.
// STRUCTURE
//  - Shared package (isa_pkg): INSTR_W=16, NOP=16'h0000, field positions shared with
//    the relayer: DEST=[10:8], SRC1=[7:5], SRC2=[4:2], IMM_FLAG=bit 11.
//  - One sub-module: fetch_ring_buffer (DEPTH x 16 storage, 2-write/2-read ports, pointers,
//    count); the top holds pc, inflight and the request/redirect control.
// TESTING
//  1. Reset, consume=0, memory words = address: first req addr 0, next 2, 4, 6;
//     stops after queue holds 8 -> outputs 0x0000/0x0001 valid, imem_req low when full.
//  2. Steady consume=2 every cycle: pairs (0,1),(2,3),(4,5)... in order, no gaps after fill.
//  3. Alternate consume=1/2: sequence 0 | 1,2 | 3 | 4,5 ...; head stays aligned, no loss/dup.
//  4. Redirect to 0x0100 while a request is in flight: dropped data never appears;
//     next pair seen is 0x0100/0x0101, two cycles after the first post-redirect request.
//  5. redirect_pc=16'hFFFF: pair FFFF/0000 fetched, next request addr 0x0001 (wrap).
//  6. Assert rst while queue has 5 entries and inflight=1: all valids low next cycle,
//     first request addr RESET_PC; consume=2 with one valid clamps to 1, count stays >= 0.

Source files
------------

// File: rtl/isa_pkg.sv
// rtl/isa_pkg.sv - shared instruction-word definitions for the fetch queue and relayer
// Purpose: instruction width, NOP encoding and register/immediate field positions
//          shared between the front-end queue and the dual-issue relayer.
// Ports:   none (package).
package isa_pkg;

   localparam int INSTR_W = 16;

   typedef logic [INSTR_W-1:0] instr_t;

   localparam instr_t NOP = 16'h0000;

   // Field positions decoded by the relayer for hazard detection.
   localparam int DEST_MSB     = 10;
   localparam int DEST_LSB     = 8;
   localparam int SRC1_MSB     = 7;
   localparam int SRC1_LSB     = 5;
   localparam int SRC2_MSB     = 4;
   localparam int SRC2_LSB     = 2;
   localparam int IMM_FLAG_BIT = 11;

   typedef logic [2:0] reg_idx_t;

   function automatic reg_idx_t dest_of(input instr_t i);
      return i[DEST_MSB:DEST_LSB];
   endfunction

   function automatic logic imm_of(input instr_t i);
      return i[IMM_FLAG_BIT];
   endfunction

endpackage

// File: rtl/fetch_ring_buffer.sv
// rtl/fetch_ring_buffer.sv - DEPTH x 16 circular buffer, two writes and two reads per cycle
// Purpose: in-order instruction storage for the fetch queue.
// Ports:   clk, rst (sync active-high), flush (drop contents), wr_en/wr_data1/wr_data2
//          (append a pair), take (0..2 entries retired at head), head1/head2 (two oldest
//          entries, undefined when not counted), count (entries held, 0..DEPTH).
module fetch_ring_buffer
   import isa_pkg::*;
#(
   parameter  int DEPTH = 8,
   localparam int PW    = $clog2(DEPTH),
   localparam int CW    = PW + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush,
   input  logic          wr_en,
   input  instr_t        wr_data1,
   input  instr_t        wr_data2,
   input  logic [1:0]    take,
   output instr_t        head1,
   output instr_t        head2,
   output logic [CW-1:0] count
);

   instr_t        mem [DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;

   // DEPTH is a power of two, so pointer arithmetic wraps for free.
   assign head1 = mem[rd_ptr];
   assign head2 = mem[rd_ptr + PW'(1)];

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) begin
            mem[wr_ptr]          <= wr_data1;
            mem[wr_ptr + PW'(1)] <= wr_data2;
            wr_ptr               <= wr_ptr + PW'(2);
         end
         rd_ptr <= rd_ptr + PW'(take);
         count  <= count - CW'(take) + (wr_en ? CW'(2) : CW'(0));
      end
   end

endmodule

// File: rtl/dual_fetch_queue.sv
// rtl/dual_fetch_queue.sv - front-end instruction queue presenting an issue pair
// Purpose: fetches two instruction words per request, buffers them in order and
//          presents the two oldest to the dual-issue relayer; redirects flush and restart.
// Ports:   clk, rst (sync active-high); imem_req/imem_addr out, imem_rdata1/2 in
//          (one-cycle latency); redirect_valid/redirect_pc in; instr1/2_out and
//          instr1/2_valid out (NOP when invalid); consume in (0..2 taken this cycle).
module dual_fetch_queue
   import isa_pkg::*;
#(
   parameter int          DEPTH    = 8,
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input  logic         clk,
   input  logic         rst,
   output logic         imem_req,
   output logic [15:0]  imem_addr,
   input  logic [15:0]  imem_rdata1,
   input  logic [15:0]  imem_rdata2,
   input  logic         redirect_valid,
   input  logic [15:0]  redirect_pc,
   output logic [15:0]  instr1_out,
   output logic [15:0]  instr2_out,
   output logic         instr1_valid,
   output logic         instr2_valid,
   input  logic [1:0]   consume
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam int SW = CW + 2;

   logic [15:0]   pc;
   logic          inflight;
   logic [CW-1:0] count;
   instr_t        head1;
   instr_t        head2;
   logic [1:0]    avail;
   logic [1:0]    take;
   logic [SW-1:0] need;
   logic [SW-1:0] limit;

   assign instr1_valid = (count != '0);
   assign instr2_valid = (count >= CW'(2));
   assign instr1_out   = instr1_valid ? head1 : NOP;
   assign instr2_out   = instr2_valid ? head2 : NOP;

   // Out-of-protocol consume values (3, or more than are valid) retire only what is there.
   assign avail = instr2_valid ? 2'd2 : (instr1_valid ? 2'd1 : 2'd0);
   assign take  = (consume > avail) ? avail : consume;

   // Reserve room for the pair already in flight plus the one being requested,
   // crediting entries retired this cycle; compared without subtraction to avoid underflow.
   assign need     = SW'(count) + (inflight ? SW'(2) : SW'(0)) + SW'(2);
   assign limit    = SW'(DEPTH) + SW'(take);
   assign imem_req = !rst && !redirect_valid && (need <= limit);
   assign imem_addr = pc;

   always_ff @(posedge clk) begin
      if (rst) begin
         pc       <= RESET_PC;
         inflight <= 1'b0;
      end else if (redirect_valid) begin
         pc       <= redirect_pc;
         inflight <= 1'b0;
      end else begin
         inflight <= imem_req;
         if (imem_req) begin
            pc <= pc + 16'd2;
         end
      end
   end

   fetch_ring_buffer #(
      .DEPTH (DEPTH)
   ) u_ring (
      .clk      (clk),
      .rst      (rst),
      .flush    (redirect_valid),
      .wr_en    (inflight),
      .wr_data1 (imem_rdata1),
      .wr_data2 (imem_rdata2),
      .take     (take),
      .head1    (head1),
      .head2    (head2),
      .count    (count)
   );

endmodule
